// File: rtl/toy_mc_core.sv
// rtl/toy_mc_core.sv - multi-cycle accumulator CPU core with a req/ready memory port
module toy_mc_core #(
    parameter int DW           = 16,
    parameter int AW           = 12,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] reg_a_out,
    output logic [DW-1:0] reg_t_out,
    output logic          flag_z,
    output logic          flag_c,
    output logic          halted,
    output logic          fault
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;
    localparam logic [3:0] OP_JC  = 4'd10;
    localparam logic [3:0] OP_MVT = 4'd11;
    localparam logic [3:0] OP_STT = 4'd12;
    localparam logic [3:0] OP_INC = 4'd13;
    localparam logic [3:0] OP_SHL = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_t;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_mdr;
    logic          r_z;
    logic          r_c;
    logic          r_fault;
    logic          r_started;
    logic [31:0]   r_wait_cnt;

    logic [3:0]    w_op;
    logic [AW-1:0] w_opnd;
    logic          w_store;
    logic          w_xfer;
    logic          w_stall;
    logic          w_timeout;
    logic          w_taken;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_inc;
    logic [DW-1:0] w_alu;
    logic          w_alu_c;

    assign w_op      = r_ir[DW-1:DW-4];
    assign w_opnd    = r_ir[AW-1:0];
    assign w_store   = (w_op == OP_STA) || (w_op == OP_STT);
    assign w_xfer    = mem_req && mem_ready;
    assign w_stall   = mem_req && !mem_ready;
    assign w_timeout = (WAIT_TIMEOUT > 0) && w_stall && (r_wait_cnt == 32'(WAIT_TIMEOUT - 1));
    assign w_taken   = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_z) || ((w_op == OP_JC) && r_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout) begin
                    w_next = S_HALT;
                end else if (w_xfer) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_HLT:                                          w_next = S_HALT;
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STT: w_next = S_MEM;
                    OP_NOT, OP_INC, OP_SHL:                          w_next = S_EXEC;
                    default:                                         w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (w_timeout) begin
                    w_next = S_HALT;
                end else if (w_xfer) begin
                    w_next = w_store ? S_FETCH : S_EXEC;
                end
            end
            S_EXEC:  w_next = S_FETCH;
            default: w_next = S_HALT;
        endcase
    end

    // r_started keeps mem_req low for the first cycle after a reset edge
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = r_pc;
        case (r_state)
            S_FETCH: mem_req = r_started;
            S_MEM: begin
                mem_req  = r_started;
                mem_we   = w_store;
                mem_addr = w_opnd;
            end
            default: ;
        endcase
    end

    assign mem_wdata = (w_op == OP_STT) ? r_t : r_a;
    assign pc_out    = r_pc;
    assign reg_a_out = r_a;
    assign reg_t_out = r_t;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign halted    = (r_state == S_HALT);
    assign fault     = r_fault;

    assign w_sum = {1'b0, r_a} + {1'b0, r_mdr};
    assign w_inc = {1'b0, r_a} + (DW+1)'(1);

    always_comb begin
        w_alu   = r_mdr;
        w_alu_c = r_c;
        case (w_op)
            OP_ADD: {w_alu_c, w_alu} = w_sum;
            OP_SUB: begin
                w_alu   = r_a - r_mdr;
                w_alu_c = (r_a < r_mdr);
            end
            OP_AND: w_alu = r_a & r_mdr;
            OP_OR:  w_alu = r_a | r_mdr;
            OP_NOT: w_alu = ~r_a;
            OP_INC: {w_alu_c, w_alu} = w_inc;
            OP_SHL: begin
                w_alu   = {r_a[DW-2:0], 1'b0};
                w_alu_c = r_a[DW-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !w_stall) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_a       <= '0;
            r_t       <= '0;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_fault   <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_xfer) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + AW'(1);
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_MVT) begin
                        r_t <= r_a;
                    end
                    if (w_taken) begin
                        r_pc <= w_opnd;
                    end
                end
                S_MEM: begin
                    if (w_xfer && !w_store) begin
                        r_mdr <= mem_rdata;
                    end
                end
                S_EXEC: begin
                    r_a <= w_alu;
                    r_c <= w_alu_c;
                    r_z <= (w_alu == '0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_toy_mc_core.sv
// tb/tb_toy_mc_core.sv - directed self-checking bench for toy_mc_core
module tb_toy_mc_core;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] mem_wdata, mem_rdata, reg_a_out, reg_t_out;
    logic          flag_z, flag_c, halted, fault;

    logic          reset2, mem_req2, mem_we2, mem_ready2;
    logic [AW-1:0] mem_addr2, pc_out2;
    logic [DW-1:0] mem_wdata2, mem_rdata2, reg_a_out2, reg_t_out2;
    logic          flag_z2, flag_c2, halted2, fault2;

    logic [DW-1:0] mem [0:4095];
    int checks;
    int failures;

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = 16'h1100;

    toy_mc_core #(.DW(DW), .AW(AW), .WAIT_TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out),
        .reg_a_out(reg_a_out), .reg_t_out(reg_t_out), .flag_z(flag_z), .flag_c(flag_c),
        .halted(halted), .fault(fault)
    );

    toy_mc_core #(.DW(DW), .AW(AW), .WAIT_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .pc_out(pc_out2),
        .reg_a_out(reg_a_out2), .reg_t_out(reg_t_out2), .flag_z(flag_z2), .flag_c(flag_c2),
        .halted(halted2), .fault(fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: drive ready, perform a completing write, advance one cycle.
    task automatic cycle(input logic rdy);
        mem_ready = rdy;
        if (mem_req && mem_we && rdy) mem[mem_addr] = mem_wdata;
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    task automatic start_dut();
        reset = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int max, output int n);
        n = 0;
        while (!halted && n < max) begin
            cycle(1'b1);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL rst_pc got=%h exp=000", pc_out); end
        checks++; if ({reg_a_out, reg_t_out} !== 32'h0) begin failures++; $display("FAIL rst_at got=%h exp=0", {reg_a_out, reg_t_out}); end
        checks++; if ({flag_z, flag_c, halted, fault} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {flag_z, flag_c, halted, fault}); end
        reset = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req_after_edge got=%b exp=0", mem_req); end
        cycle(1'b1);
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 12'h000}) begin failures++; $display("FAIL rst_first_fetch got=%b%b/%h exp=10/000", mem_req, mem_we, mem_addr); end
    endtask

    task automatic test_add_carry();
        int n;
        clear_mem();
        mem[0] = 16'h1100; mem[1] = 16'h3101; mem[2] = 16'hF000;
        mem[12'h100] = 16'hFFFF; mem[12'h101] = 16'h0001;
        start_dut();
        run_to_halt(100, n);
        checks++; if (n !== 11) begin failures++; $display("FAIL add_cycles got=%0d exp=11", n); end
        checks++; if (reg_a_out !== 16'h0000) begin failures++; $display("FAIL add_a got=%h exp=0000", reg_a_out); end
        checks++; if ({flag_z, flag_c, halted, fault} !== 4'b1110) begin failures++; $display("FAIL add_flags got=%b exp=1110", {flag_z, flag_c, halted, fault}); end
        checks++; if (pc_out !== 12'h003) begin failures++; $display("FAIL add_pc got=%h exp=003", pc_out); end
    endtask

    task automatic test_sub_jc();
        int n;
        clear_mem();
        mem[0] = 16'h1102; mem[1] = 16'h4103; mem[2] = 16'hA020; mem[12'h020] = 16'hF000;
        mem[12'h102] = 16'h0003; mem[12'h103] = 16'h0005;
        start_dut();
        for (int i = 0; i < 11; i++) cycle(1'b1);
        checks++; if (pc_out !== 12'h020) begin failures++; $display("FAIL jc_pc got=%h exp=020", pc_out); end
        checks++; if ({mem_req, mem_addr} !== {1'b1, 12'h020}) begin failures++; $display("FAIL jc_fetch got=%b/%h exp=1/020", mem_req, mem_addr); end
        checks++; if (reg_a_out !== 16'hFFFE) begin failures++; $display("FAIL sub_a got=%h exp=fffe", reg_a_out); end
        checks++; if ({flag_z, flag_c} !== 2'b01) begin failures++; $display("FAIL sub_zc got=%b exp=01", {flag_z, flag_c}); end
        run_to_halt(50, n);
        checks++; if ({halted, pc_out} !== {1'b1, 12'h021}) begin failures++; $display("FAIL jc_halt got=%b/%h exp=1/021", halted, pc_out); end
    endtask

    task automatic test_logic();
        int n;
        clear_mem();
        mem[0] = 16'h1106; mem[1] = 16'h5107; mem[2] = 16'h6108; mem[3] = 16'h7000;
        mem[4] = 16'hD000; mem[5] = 16'h2070; mem[6] = 16'h9030; mem[7] = 16'h1100;
        mem[8] = 16'hD000; mem[9] = 16'h9040; mem[10] = 16'hF000;
        mem[12'h030] = 16'hF000; mem[12'h040] = 16'hF000;
        mem[12'h100] = 16'hFFFF; mem[12'h106] = 16'h00F0; mem[12'h107] = 16'h0F3C; mem[12'h108] = 16'h8001;
        start_dut();
        run_to_halt(200, n);
        checks++; if (n !== 35) begin failures++; $display("FAIL logic_cycles got=%0d exp=35", n); end
        checks++; if (mem[12'h070] !== 16'h7FCF) begin failures++; $display("FAIL logic_store got=%h exp=7fcf", mem[12'h070]); end
        checks++; if (reg_a_out !== 16'h0000) begin failures++; $display("FAIL inc_wrap_a got=%h exp=0000", reg_a_out); end
        checks++; if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL inc_wrap_zc got=%b exp=11", {flag_z, flag_c}); end
        checks++; if (pc_out !== 12'h041) begin failures++; $display("FAIL jz_pc got=%h exp=041", pc_out); end
    endtask

    task automatic test_pc_wrap();
        int n;
        clear_mem();
        mem[0] = 16'hA010; mem[1] = 16'h1105; mem[2] = 16'hE000; mem[3] = 16'h8FFF;
        mem[12'h010] = 16'hB000; mem[12'h011] = 16'hC050; mem[12'h012] = 16'hF000;
        mem[12'h105] = 16'h8001;
        start_dut();
        for (int i = 0; i < 12; i++) cycle(1'b1);
        checks++; if ({mem_req, mem_addr} !== {1'b1, 12'hFFF}) begin failures++; $display("FAIL wrap_fetch got=%b/%h exp=1/fff", mem_req, mem_addr); end
        cycle(1'b1);
        checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL wrap_pc got=%h exp=000", pc_out); end
        run_to_halt(100, n);
        checks++; if (mem[12'h050] !== 16'h0002) begin failures++; $display("FAIL stt_mem got=%h exp=0002", mem[12'h050]); end
        checks++; if ({reg_t_out, flag_c, flag_z} !== {16'h0002, 2'b10}) begin failures++; $display("FAIL mvt_shl got=%h/%b%b exp=0002/10", reg_t_out, flag_c, flag_z); end
        checks++; if ({halted, pc_out} !== {1'b1, 12'h013}) begin failures++; $display("FAIL wrap_halt got=%b/%h exp=1/013", halted, pc_out); end
    endtask

    task automatic test_stalls();
        int waits, n, wl, exp_n;
        logic have, rdy, p_stall, p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        for (int rep = 0; rep < 3; rep++) begin
            clear_mem();
            mem[12'h100] = 16'hFFFF; mem[12'h101] = 16'h0001; mem[12'h104] = 16'h1234;
            if (rep == 2) begin
                mem[0] = 16'h1104; mem[1] = 16'h2061; mem[2] = 16'h1100; mem[3] = 16'h3101; mem[4] = 16'hF000;
            end else begin
                mem[0] = 16'h1100; mem[1] = 16'h3101; mem[2] = 16'hF000;
            end
            start_dut();
            waits = 0; n = 0; wl = 0; have = 1'b0; p_stall = 1'b0;
            p_we = 1'b0; p_addr = '0; p_wdata = '0;
            while (!halted && n < 300) begin
                if (p_stall) begin
                    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, p_we, p_addr, p_wdata}) begin failures++; $display("FAIL stall_hold got=%b%b/%h/%h exp=1%b/%h/%h", mem_req, mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wdata); end
                end
                rdy = 1'b1;
                if (mem_req) begin
                    if (!have) begin wl = $urandom_range(0, 3); have = 1'b1; end
                    if (wl > 0) begin rdy = 1'b0; wl--; waits++; end
                    else have = 1'b0;
                end
                p_stall = mem_req && !rdy; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
                cycle(rdy);
                n++;
            end
            exp_n = ((rep == 2) ? 18 : 11) + waits;
            checks++; if (n !== exp_n) begin failures++; $display("FAIL stall_cycles rep=%0d got=%0d exp=%0d", rep, n, exp_n); end
            checks++; if ({reg_a_out, flag_z, flag_c, halted} !== {16'h0000, 3'b111}) begin failures++; $display("FAIL stall_final rep=%0d got=%h/%b%b%b exp=0000/111", rep, reg_a_out, flag_z, flag_c, halted); end
            if (rep == 2) begin
                checks++; if (mem[12'h061] !== 16'h1234) begin failures++; $display("FAIL stall_store got=%h exp=1234", mem[12'h061]); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        clear_mem();
        mem[0] = 16'h1104; mem[1] = 16'h2062; mem[12'h104] = 16'h1234;
        start_dut();
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin cycle(1'b1); n++; end
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 12'h062}) begin failures++; $display("FAIL mw_reach got=%b%b/%h exp=11/062", mem_req, mem_we, mem_addr); end
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b1;
        cycle(1'b0);
        checks++; if ({mem_req, mem_we} !== 2'b00) begin failures++; $display("FAIL mw_req got=%b%b exp=00", mem_req, mem_we); end
        checks++; if ({pc_out, reg_a_out, reg_t_out} !== 44'h0) begin failures++; $display("FAIL mw_regs got=%h/%h/%h exp=0", pc_out, reg_a_out, reg_t_out); end
        checks++; if ({flag_z, flag_c, halted, fault} !== 4'b0000) begin failures++; $display("FAIL mw_flags got=%b exp=0000", {flag_z, flag_c, halted, fault}); end
        checks++; if (mem[12'h062] !== 16'h0000) begin failures++; $display("FAIL mw_nowrite got=%h exp=0000", mem[12'h062]); end
        reset = 1'b0;
        cycle(1'b1);
        checks++; if ({mem_req, mem_addr} !== {1'b1, 12'h000}) begin failures++; $display("FAIL mw_restart got=%b/%h exp=1/000", mem_req, mem_addr); end
    endtask

    task automatic test_timeout();
        reset2 = 1'b1;
        cycle(1'b1);
        reset2 = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1);
        checks++; if ({mem_req2, mem_we2, mem_addr2, halted2, fault2} !== {2'b10, 12'h000, 2'b00}) begin failures++; $display("FAIL to_pending got=%b%b/%h/%b%b exp=10/000/00", mem_req2, mem_we2, mem_addr2, halted2, fault2); end
        cycle(1'b1);
        checks++; if ({fault2, halted2, mem_req2} !== 3'b110) begin failures++; $display("FAIL to_fault got=%b exp=110", {fault2, halted2, mem_req2}); end
        checks++; if ({reg_a_out2, reg_t_out2, pc_out2, mem_wdata2} !== 60'h0) begin failures++; $display("FAIL to_state got=%h/%h/%h/%h exp=0", reg_a_out2, reg_t_out2, pc_out2, mem_wdata2); end
        checks++; if ({flag_z2, flag_c2} !== 2'b00) begin failures++; $display("FAIL to_flags got=%b exp=00", {flag_z2, flag_c2}); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        reset2 = 1'b1;
        mem_ready = 1'b1;
        mem_ready2 = 1'b0;
        clear_mem();
        test_reset();
        test_add_carry();
        test_sub_jc();
        test_logic();
        test_pc_wrap();
        test_stalls();
        test_reset_mid_write();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
